// File: rtl/inst_cache_refill.sv
// Direct-mapped instruction cache with a line-refill state machine.
// Hits answer one cycle after acceptance; misses fetch the full line from
// memory over a valid/ready handshake, install it, then answer.
module inst_cache_refill #(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_inst,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [WORD_W-1:0] mem_resp_data,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam logic [OFFSET_W-1:0] LAST_BEAT = {OFFSET_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FILL_REQ  = 2'd1,
    S_FILL_DATA = 2'd2,
    S_RESPOND   = 2'd3
  } state_t;

  state_t state_r, state_nx_s;

  // Storage arrays carry no reset; the valid bits gate their use.
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [LINES*WORDS];
  logic [LINES-1:0]  valid_r;

  logic [TAG_W-1:0]    tag_lat_r;
  logic [INDEX_W-1:0]  idx_lat_r;
  logic [OFFSET_W-1:0] off_lat_r;
  logic [OFFSET_W-1:0] beat_r;
  logic                flush_pend_r;
  logic                resp_valid_r;
  logic [WORD_W-1:0]   resp_inst_r;
  logic                mem_req_valid_r;
  logic [ADDR_W-1:0]   mem_req_addr_r;
  logic [31:0]         hit_count_r;
  logic [31:0]         miss_count_r;

  logic [TAG_W-1:0]    req_tag_s;
  logic [INDEX_W-1:0]  req_idx_s;
  logic [OFFSET_W-1:0] req_off_s;
  logic                hit_s;
  logic                accept_s;
  logic                beat_we_s;
  logic                last_beat_s;
  logic                idle_clear_s;

  assign req_tag_s    = req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign req_idx_s    = req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign req_off_s    = req_addr[OFFSET_W-1:0];
  assign hit_s        = valid_r[req_idx_s] && (tag_mem[req_idx_s] == req_tag_s);
  // A flush pending from a fill blocks acceptance on the cycle IDLE is re-entered.
  assign req_ready    = (state_r == S_IDLE) && !flush && !flush_pend_r;
  assign accept_s     = req_valid && req_ready;
  assign beat_we_s    = (state_r == S_FILL_DATA) && mem_resp_valid;
  assign last_beat_s  = beat_we_s && (beat_r == LAST_BEAT);
  assign idle_clear_s = (state_r == S_IDLE) && (flush || flush_pend_r);

  assign resp_valid    = resp_valid_r;
  assign resp_inst     = resp_inst_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = mem_req_addr_r;
  assign hit_count     = hit_count_r;
  assign miss_count    = miss_count_r;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && !hit_s) state_nx_s = S_FILL_REQ;
        else                    state_nx_s = S_IDLE;
      end
      S_FILL_REQ: begin
        if (mem_req_ready) state_nx_s = S_FILL_DATA;
        else               state_nx_s = S_FILL_REQ;
      end
      S_FILL_DATA: begin
        if (last_beat_s) state_nx_s = S_RESPOND;
        else             state_nx_s = S_FILL_DATA;
      end
      S_RESPOND: state_nx_s = S_IDLE;
      default:   state_nx_s = S_IDLE;
    endcase
  end

  // Tag and data array writes during refill.
  always_ff @(posedge clk) begin
    if (beat_we_s) begin
      data_mem[{idx_lat_r, beat_r}] <= mem_resp_data;
    end
    if (last_beat_s) begin
      tag_mem[idx_lat_r] <= tag_lat_r;
    end
  end

  // Control datapath: responses, fill request, valid bits, counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r         <= '0;
      tag_lat_r       <= '0;
      idx_lat_r       <= '0;
      off_lat_r       <= '0;
      beat_r          <= '0;
      flush_pend_r    <= 1'b0;
      resp_valid_r    <= 1'b0;
      resp_inst_r     <= '0;
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= '0;
      hit_count_r     <= 32'd0;
      miss_count_r    <= 32'd0;
    end else begin
      resp_valid_r <= 1'b0;
      if (accept_s) begin
        tag_lat_r <= req_tag_s;
        idx_lat_r <= req_idx_s;
        off_lat_r <= req_off_s;
        if (hit_s) begin
          resp_valid_r <= 1'b1;
          resp_inst_r  <= data_mem[{req_idx_s, req_off_s}];
          if (hit_count_r != 32'hFFFF_FFFF) hit_count_r <= hit_count_r + 32'd1;
        end else begin
          mem_req_valid_r <= 1'b1;
          mem_req_addr_r  <= {req_tag_s, req_idx_s, {OFFSET_W{1'b0}}};
          if (miss_count_r != 32'hFFFF_FFFF) miss_count_r <= miss_count_r + 32'd1;
        end
      end
      if ((state_r == S_FILL_REQ) && mem_req_ready) begin
        mem_req_valid_r <= 1'b0;
        beat_r          <= '0;
      end
      if (beat_we_s) begin
        beat_r <= beat_r + {{(OFFSET_W-1){1'b0}}, 1'b1};
      end
      // The requested word may be the beat arriving right now.
      if (last_beat_s) begin
        resp_valid_r <= 1'b1;
        if (off_lat_r == LAST_BEAT) resp_inst_r <= mem_resp_data;
        else                        resp_inst_r <= data_mem[{idx_lat_r, off_lat_r}];
      end
      if (state_r == S_IDLE)  flush_pend_r <= 1'b0;
      else if (flush)         flush_pend_r <= 1'b1;
      if (idle_clear_s)       valid_r <= '0;
      else if (last_beat_s)   valid_r[idx_lat_r] <= 1'b1;
    end
  end

endmodule
